// File: rtl/q_learning_agent_param_if.sv
// Agent <-> environment handshake bundle for the parametrised Q-learning agent.
// master = environment/driver side, slave = agent.
interface q_learning_agent_param_if #(
   parameter int N_STATES  = 64,
   parameter int N_ACTIONS = 4,
   parameter int Q_W       = 16
);
   localparam int STATE_W = $clog2(N_STATES);
   localparam int ACT_W   = $clog2(N_ACTIONS);

   logic                      en;
   logic                      start;
   logic [STATE_W-1:0]        start_state;
   logic [15:0]               epsilon;
   logic                      env_valid;
   logic                      env_terminal;
   logic [STATE_W-1:0]        next_state;
   logic signed [Q_W-1:0]     next_reward;
   logic [ACT_W-1:0]          next_action;
   logic                      action_valid;
   logic                      busy;
   logic [15:0]               step_count;

   modport master (
      output en, start, start_state, epsilon, env_valid, env_terminal, next_state, next_reward,
      input  next_action, action_valid, busy, step_count
   );

   modport slave (
      input  en, start, start_state, epsilon, env_valid, env_terminal, next_state, next_reward,
      output next_action, action_valid, busy, step_count
   );
endinterface

// File: rtl/q_learning_agent_param.sv
// Q-learning agent: on-chip Q-table, epsilon-greedy selection via LFSR, shift-based Q-update.
//
// state     | meaning
// ST_CLEAR  | zero one table row per cycle after reset, busy high
// ST_IDLE   | wait for start
// ST_READ_S | fetch row(s) into held row (address cycle, then capture)
// ST_SELECT | explore/greedy pick, raise action_valid, step LFSR
// ST_WAIT   | action presented, wait for env_valid
// ST_READ_N | fetch row(s'), compute saturated Qn
// ST_UPDATE | write Qn into lane a of row s, advance to s'
module q_learning_agent_param #(
   parameter int          N_STATES    = 64,
   parameter int          N_ACTIONS   = 4,
   parameter int          Q_W         = 16,
   parameter int          ALPHA_SHIFT = 2,
   parameter int          GAMMA_SHIFT = 3,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input logic                        clk,
   input logic                        rst_n,
   q_learning_agent_param_if.slave    bus
);
   localparam int STATE_W = $clog2(N_STATES);
   localparam int ACT_W   = $clog2(N_ACTIONS);
   localparam int ROW_W   = N_ACTIONS * Q_W;
   localparam int EXT_W   = Q_W + 3;
   localparam logic [STATE_W:0] PTR_END = (STATE_W+1)'(N_STATES);

   typedef enum logic [2:0] {
      ST_CLEAR, ST_IDLE, ST_READ_S, ST_SELECT, ST_WAIT, ST_READ_N, ST_UPDATE
   } state_t;

   state_t                state_q, state_d;
   logic [STATE_W:0]      clr_ptr_q, clr_ptr_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic [STATE_W-1:0]    s_q, s_d, sn_q, sn_d, rd_addr_q, rd_addr_d;
   logic signed [Q_W-1:0] rw_q, rw_d, qn_q, qn_d;
   logic                  term_q, term_d, rd_ph_q, rd_ph_d;
   logic [ACT_W-1:0]      act_q, act_d;
   logic                  av_q, av_d, busy_q, busy_d;
   logic [15:0]           steps_q, steps_d;
   logic [ROW_W-1:0]      held_q, held_d, rown_q, rown_d;

   logic [ROW_W-1:0]      q_tbl_q [N_STATES];
   logic [ROW_W-1:0]      rd_data_q;
   logic                  we;
   logic [STATE_W-1:0]    wr_addr;
   logic [ROW_W-1:0]      wr_data, upd_row;

   function automatic logic [ACT_W-1:0] row_argmax(input logic [ROW_W-1:0] row);
      logic signed [Q_W-1:0] best;
      row_argmax = '0;
      best = row[Q_W-1:0];
      for (int i = 1; i < N_ACTIONS; i++) begin
         if ($signed(row[i*Q_W +: Q_W]) > best) begin
            best       = row[i*Q_W +: Q_W];
            row_argmax = ACT_W'(i);
         end
      end
   endfunction

   always_ff @(posedge clk) begin
      if (bus.en) begin
         if (we) q_tbl_q[wr_addr] <= wr_data;
         rd_data_q <= q_tbl_q[rd_addr_q];
      end
   end

   // Q-update datapath; the widened format absorbs r + m - Q before saturation
   logic signed [Q_W-1:0]   qsa, mmax;
   logic signed [EXT_W-1:0] qsa_x, m_x, rw_x, t_x, qn_x;
   logic signed [Q_W-1:0]   qn_sat;
   logic                    explore;

   always_comb begin
      qsa   = held_q[act_q*Q_W +: Q_W];
      mmax  = term_q ? '0 : rd_data_q[row_argmax(rd_data_q)*Q_W +: Q_W];
      qsa_x = {{(EXT_W-Q_W){qsa[Q_W-1]}}, qsa};
      m_x   = {{(EXT_W-Q_W){mmax[Q_W-1]}}, mmax};
      rw_x  = {{(EXT_W-Q_W){rw_q[Q_W-1]}}, rw_q};
      t_x   = rw_x + m_x - (m_x >>> GAMMA_SHIFT) - qsa_x;
      qn_x  = qsa_x + (t_x >>> ALPHA_SHIFT);
      if (qn_x[EXT_W-1:Q_W-1] == {(EXT_W-Q_W+1){qn_x[EXT_W-1]}})
         qn_sat = qn_x[Q_W-1:0];
      else if (qn_x[EXT_W-1])
         qn_sat = {1'b1, {(Q_W-1){1'b0}}};
      else
         qn_sat = {1'b0, {(Q_W-1){1'b1}}};
   end

   always_comb begin
      upd_row = held_q;
      upd_row[act_q*Q_W +: Q_W] = qn_q;
   end

   assign explore = lfsr_q < bus.epsilon;

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      lfsr_d    = lfsr_q;
      s_d       = s_q;
      sn_d      = sn_q;
      rd_addr_d = rd_addr_q;
      rw_d      = rw_q;
      qn_d      = qn_q;
      term_d    = term_q;
      rd_ph_d   = rd_ph_q;
      act_d     = act_q;
      av_d      = av_q;
      busy_d    = busy_q;
      steps_d   = steps_q;
      held_d    = held_q;
      rown_d    = rown_q;
      we        = 1'b0;
      wr_addr   = s_q;
      wr_data   = upd_row;
      if (bus.en) begin
         unique case (state_q)
            ST_CLEAR: begin
               if (clr_ptr_q == PTR_END) begin
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  we        = 1'b1;
                  wr_addr   = clr_ptr_q[STATE_W-1:0];
                  wr_data   = '0;
                  clr_ptr_d = clr_ptr_q + 1'b1;
               end
            end
            ST_IDLE: begin
               if (bus.start) begin
                  s_d       = bus.start_state;
                  rd_addr_d = bus.start_state;
                  steps_d   = '0;
                  rd_ph_d   = 1'b0;
                  state_d   = ST_READ_S;
               end
            end
            ST_READ_S: begin
               rd_ph_d = 1'b1;
               if (rd_ph_q) begin
                  held_d  = rd_data_q;
                  state_d = ST_SELECT;
               end
            end
            ST_SELECT: begin
               act_d   = explore ? lfsr_q[ACT_W-1:0] : row_argmax(held_q);
               av_d    = 1'b1;
               lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.env_valid) begin
                  sn_d      = bus.next_state;
                  rd_addr_d = bus.next_state;
                  rw_d      = bus.next_reward;
                  term_d    = bus.env_terminal;
                  av_d      = 1'b0;
                  rd_ph_d   = 1'b0;
                  state_d   = ST_READ_N;
               end
            end
            ST_READ_N: begin
               rd_ph_d = 1'b1;
               if (rd_ph_q) begin
                  rown_d  = rd_data_q;
                  qn_d    = qn_sat;
                  state_d = ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               we      = 1'b1;
               steps_d = (steps_q == 16'hFFFF) ? steps_q : steps_q + 16'd1;
               if (term_q) begin
                  state_d = ST_IDLE;
               end else begin
                  s_d     = sn_q;
                  // row(s') was fetched before this write lands, so a self-loop takes the fresh row
                  held_d  = (sn_q == s_q) ? upd_row : rown_q;
                  state_d = ST_SELECT;
               end
            end
            default: state_d = ST_CLEAR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
         lfsr_q    <= LFSR_SEED;
         s_q       <= '0;
         sn_q      <= '0;
         rd_addr_q <= '0;
         rw_q      <= '0;
         qn_q      <= '0;
         term_q    <= 1'b0;
         rd_ph_q   <= 1'b0;
         act_q     <= '0;
         av_q      <= 1'b0;
         busy_q    <= 1'b1;
         steps_q   <= '0;
         held_q    <= '0;
         rown_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         lfsr_q    <= lfsr_d;
         s_q       <= s_d;
         sn_q      <= sn_d;
         rd_addr_q <= rd_addr_d;
         rw_q      <= rw_d;
         qn_q      <= qn_d;
         term_q    <= term_d;
         rd_ph_q   <= rd_ph_d;
         act_q     <= act_d;
         av_q      <= av_d;
         busy_q    <= busy_d;
         steps_q   <= steps_d;
         held_q    <= held_d;
         rown_q    <= rown_d;
      end
   end

   assign bus.next_action  = act_q;
   assign bus.action_valid = av_q;
   assign bus.busy         = busy_q;
   assign bus.step_count   = steps_q;
endmodule

// File: tb/tb_q_learning_agent_param.sv
// Directed bench for q_learning_agent_param: vector table for episodes plus
// hand-written self-loop, enable-freeze, mid-episode reset and explore sequences.
module tb_q_learning_agent_param;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   q_learning_agent_param_if #(.N_STATES(64), .N_ACTIONS(4), .Q_W(16)) bus ();

   q_learning_agent_param #(
      .N_STATES(64), .N_ACTIONS(4), .Q_W(16), .ALPHA_SHIFT(2), .GAMMA_SHIFT(3), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int n_checks = 0;
   int n_errs   = 0;

   typedef struct {
      bit do_start;
      int st;
      int exp_act;
      int ns;
      int rw;
      bit term;
      int exp_q;
      int exp_steps;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_av(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.action_valid && n < 20);
   endtask

   task automatic start_ep(input int s, output int lat);
      bus.start_state = 6'(s);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_av(lat);
   endtask

   task automatic env_step(input int ns, input int rw, input bit term, output int lat);
      bus.next_state   = 6'(ns);
      bus.next_reward  = 16'(rw);
      bus.env_terminal = term;
      bus.env_valid    = 1'b1;
      tick();
      bus.env_valid    = 1'b0;
      bus.env_terminal = 1'b0;
      lat = 0;
      if (!term) wait_av(lat);
      else repeat (6) tick();
   endtask

   function automatic int get_q(input int s, input int a);
      logic [15:0] v;
      v = dut.q_tbl_q[s][a*16 +: 16];
      return int'($signed(v));
   endfunction

   function automatic int model_q(input int q, input int m, input int r);
      int t, n;
      t = r + m - (m >>> 3) - q;
      n = q + (t >>> 2);
      if (n > 32767) n = 32767;
      if (n < -32768) n = -32768;
      return n;
   endfunction

   task automatic clear_sweep(output int nb);
      nb = 0;
      for (int i = 0; i < 100; i++) begin
         bus.start = (i == 10);
         bus.start_state = 6'd9;
         tick();
         if (bus.busy) nb++;
         else break;
      end
      bus.start = 1'b0;
   endtask

   initial begin
      int lat, nb, cur_s, qm, m, prev, mism, bad_lat, neg, nonmono, nz, exp_a, nzc;
      logic [15:0] l;

      //            start st  act ns   rw      term exp_q  steps
      vecs[0] = '{1'b1, 5, 0, 6,  256,   1'b0, 64,    1};
      vecs[1] = '{1'b0, 0, 0, 0,  0,     1'b1, 0,     2};
      vecs[2] = '{1'b1, 5, 0, 6,  -256,  1'b0, -16,   1};
      vecs[3] = '{1'b0, 0, 0, 0,  0,     1'b1, 0,     2};
      vecs[4] = '{1'b1, 5, 1, 0,  256,   1'b1, 64,    1};
      vecs[5] = '{1'b1, 3, 0, 9,  256,   1'b1, 64,    1};
      vecs[6] = '{1'b1, 3, 0, 4,  0,     1'b0, 48,    1};
      vecs[7] = '{1'b0, 0, 0, 3,  100,   1'b0, 35,    2};
      vecs[8] = '{1'b0, 0, 0, 0,  -32768,1'b1, -8156, 3};

      bus.en = 1'b1;
      bus.start = 1'b0;
      bus.start_state = '0;
      bus.epsilon = 16'h0000;
      bus.env_valid = 1'b0;
      bus.env_terminal = 1'b0;
      bus.next_state = '0;
      bus.next_reward = '0;

      repeat (3) tick();
      check("rst_busy", int'(bus.busy), 1);
      check("rst_action", int'(bus.next_action), 0);
      check("rst_av", int'(bus.action_valid), 0);
      check("rst_steps", int'(bus.step_count), 0);
      rst_n = 1'b1;
      clear_sweep(nb);
      check("clear_cycles", nb, 64);
      repeat (5) tick();
      check("start_while_busy", int'(bus.action_valid), 0);

      cur_s = 0;
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].do_start) begin
            start_ep(vecs[i].st, lat);
            check($sformatf("v%0d_start_lat", i), lat, 3);
            cur_s = vecs[i].st;
         end
         check($sformatf("v%0d_action", i), int'(bus.next_action), vecs[i].exp_act);
         env_step(vecs[i].ns, vecs[i].rw, vecs[i].term, lat);
         if (vecs[i].term) check($sformatf("v%0d_term_av", i), int'(bus.action_valid), 0);
         else check($sformatf("v%0d_env_lat", i), lat, 4);
         check($sformatf("v%0d_q", i), get_q(cur_s, vecs[i].exp_act), vecs[i].exp_q);
         check($sformatf("v%0d_steps", i), int'(bus.step_count), vecs[i].exp_steps);
         cur_s = vecs[i].ns;
      end

      // self-loop on state 2 with maximal reward
      start_ep(2, lat);
      check("loop_start_lat", lat, 3);
      qm = 0; mism = 0; bad_lat = 0; neg = 0; nonmono = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.next_action != 2'd0) mism++;
         env_step(2, 32767, 1'b0, lat);
         if (lat != 4) bad_lat++;
         prev = get_q(2, 0);
         m = (qm > 0) ? qm : 0;
         qm = model_q(qm, m, 32767);
         if (prev != qm) mism++;
         if (prev < 0) neg++;
         if (k > 0 && prev < qm - 1000000) nonmono++;
      end
      check("loop_model_mismatches", mism, 0);
      check("loop_latency_bad", bad_lat, 0);
      check("loop_negative", neg, 0);
      check("loop_saturated", get_q(2, 0), 32767);
      check("loop_steps", int'(bus.step_count), 40);

      // en low while waiting: env_valid must be ignored and nothing moves
      bus.en = 1'b0;
      bus.next_state = 6'd2;
      bus.next_reward = 16'd0;
      bus.env_terminal = 1'b1;
      bus.env_valid = 1'b1;
      repeat (10) tick();
      check("frz_wait_av", int'(bus.action_valid), 1);
      check("frz_wait_act", int'(bus.next_action), 0);
      check("frz_wait_steps", int'(bus.step_count), 40);
      check("frz_wait_q", get_q(2, 0), 32767);
      bus.en = 1'b1;
      tick();
      bus.env_valid = 1'b0;
      bus.env_terminal = 1'b0;
      bus.en = 1'b0;
      repeat (10) tick();
      check("frz_readn_av", int'(bus.action_valid), 0);
      check("frz_readn_steps", int'(bus.step_count), 40);
      check("frz_readn_q", get_q(2, 0), 32767);
      bus.en = 1'b1;
      repeat (6) tick();
      qm = model_q(qm, 0, 0);
      check("frz_after_q", get_q(2, 0), qm);
      check("frz_after_steps", int'(bus.step_count), 41);
      check("frz_after_av", int'(bus.action_valid), 0);

      // asynchronous reset while in READ_N
      start_ep(7, lat);
      check("rstmid_start_lat", lat, 3);
      bus.next_state = 6'd7;
      bus.next_reward = 16'd5;
      bus.env_valid = 1'b1;
      tick();
      bus.env_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_busy", int'(bus.busy), 1);
      check("rstmid_av", int'(bus.action_valid), 0);
      check("rstmid_steps", int'(bus.step_count), 0);
      tick();
      rst_n = 1'b1;
      clear_sweep(nb);
      check("rstmid_clear_cycles", nb, 64);
      nzc = 0;
      for (int s = 0; s < 64; s++)
         for (int a = 0; a < 4; a++)
            if (get_q(s, a) != 0) nzc++;
      check("rstmid_table_zero", nzc, 0);

      // explore ratio with epsilon at half scale; Q stays zero so greedy is lane 0
      bus.epsilon = 16'h8000;
      l = 16'hACE1;
      start_ep(0, lat);
      check("expl_start_lat", lat, 3);
      mism = 0; bad_lat = 0; nz = 0;
      for (int i = 0; i < 2000; i++) begin
         exp_a = (l < 16'h8000) ? int'(l[1:0]) : 0;
         if (int'(bus.next_action) != exp_a) mism++;
         if (bus.next_action != 2'd0) nz++;
         l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
         if (i < 1999) begin
            env_step(0, 0, 1'b0, lat);
            if (lat != 4) begin
               bad_lat++;
               break;
            end
         end
      end
      check("expl_action_mismatches", mism, 0);
      check("expl_latency_bad", bad_lat, 0);
      // 40..60% explores, 3 of 4 explore actions are nonzero
      check("expl_ratio_in_range", int'(nz >= 600 && nz <= 900), 1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
